// File: rtl/tag_frame_pack_if.sv
// Stream bundle (valid/ready/data/user/last) shared by the packer's input and output sides.
interface tag_frame_pack_if #(
  parameter int DW = 64,
  parameter int UW = 1
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic          tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/tag_frame_pack.sv
// Packs NUM_CHANNELS channel words into one wide beat and accumulates a per-frame tag bitmap.
// Optional sticky error status is enabled by defining TAG_FRAME_PACK_ERR_EN.
module tag_frame_pack #(
  parameter int NUM_TAGS      = 20,
  parameter int NUM_CHANNELS  = 4,
  parameter int CHANNEL_WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  tag_frame_pack_if.slave  s_axis,
  tag_frame_pack_if.master m_axis
`ifdef TAG_FRAME_PACK_ERR_EN
  ,
  input  logic             err_clr,
  output logic [2:0]       err_status
`endif
);
  localparam int DATA_WIDTH = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int TAG_BITS   = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int CNT_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_CHANNELS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d, beat;
  logic [TAG_BITS-1:0]   tag_q, tag_d, cur_tag;
  logic [NUM_TAGS-1:0]   bmp_q, bmp_d, tag_oh, bmp_next;
  logic                  ovld_q, ovld_d, olast_q, olast_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [NUM_TAGS-1:0]   ouser_q, ouser_d;
  logic                  s_fire, beat_done;

  assign s_axis.tready = ~ovld_q | m_axis.tready;
  assign s_fire        = s_axis.tvalid & s_axis.tready;
  assign beat_done     = s_fire & ((cnt_q == CNT_MAX) | s_axis.tlast);
  // The lane-0 word carries the beat's tag; it is not registered yet when that word also ends the beat.
  assign cur_tag       = (cnt_q == '0) ? s_axis.tuser : tag_q;

  assign m_axis.tvalid = ovld_q;
  assign m_axis.tdata  = odata_q;
  assign m_axis.tuser  = ouser_q;
  assign m_axis.tlast  = olast_q;

  for (genvar l = 0; l < NUM_CHANNELS; l++) begin : g_lane
    assign beat[l*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
      (cnt_q == CNT_W'(l)) ? s_axis.tdata : asm_q[l*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  end

  // Out-of-range tags decode to an all-zero one-hot and so mark nothing.
  for (genvar t = 0; t < NUM_TAGS; t++) begin : g_tag
    assign tag_oh[t] = (cur_tag == TAG_BITS'(t));
  end
  assign bmp_next = bmp_q | tag_oh;

  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    tag_d   = tag_q;
    bmp_d   = bmp_q;
    ovld_d  = ovld_q;
    odata_d = odata_q;
    ouser_d = ouser_q;
    olast_d = olast_q;
    if (m_axis.tready) ovld_d = 1'b0;
    if (s_fire) begin
      if (cnt_q == '0) tag_d = s_axis.tuser;
      if (beat_done) begin
        // Clearing the assembly here leaves unused lanes zero on a short final beat.
        cnt_d   = '0;
        asm_d   = '0;
        ovld_d  = 1'b1;
        odata_d = beat;
        olast_d = s_axis.tlast;
        ouser_d = s_axis.tlast ? bmp_next : '0;
        bmp_d   = s_axis.tlast ? '0 : bmp_next;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        asm_d = beat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      tag_q   <= '0;
      bmp_q   <= '0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
      ouser_q <= '0;
      olast_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      tag_q   <= tag_d;
      bmp_q   <= bmp_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
      ouser_q <= ouser_d;
      olast_q <= olast_d;
    end
  end

`ifdef TAG_FRAME_PACK_ERR_EN
  logic [2:0] err_q, err_d, err_set;

  always_comb begin
    err_set[0] = beat_done & s_axis.tlast & (cnt_q != CNT_MAX);
    err_set[1] = beat_done & ~|tag_oh;
    err_set[2] = beat_done & |(tag_oh & bmp_q);
    err_d      = (err_clr ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_status = err_q;
`endif
endmodule

// File: tb/tb_tag_frame_pack.sv
// Directed bench for tag_frame_pack: packing, stalls, short frames, bad/duplicate tags, reset.
module tb_tag_frame_pack;
  localparam int NT = 20, NC = 4, CW = 64, DW = NC * CW, TB = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tag_frame_pack_if #(.DW(CW), .UW(TB)) s_if ();
  tag_frame_pack_if #(.DW(DW), .UW(NT)) m_if ();

`ifdef TAG_FRAME_PACK_ERR_EN
  logic       err_clr = 1'b0;
  logic [2:0] err_status;
`endif

  tag_frame_pack #(.NUM_TAGS(NT), .NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (s_if),
    .m_axis (m_if)
`ifdef TAG_FRAME_PACK_ERR_EN
    ,
    .err_clr    (err_clr),
    .err_status (err_status)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [NT-1:0] u;
    logic          l;
  } beat_t;
  beat_t q[$];

  int n_cmp = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n && m_if.tvalid && m_if.tready) q.push_back('{m_if.tdata, m_if.tuser, m_if.tlast});

  // Drives one word and returns at posedge+1 after it was accepted.
  task automatic send(input logic [CW-1:0] d, input logic [TB-1:0] t, input logic l);
    bit ok = 1'b0;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tuser = t; s_if.tlast = l;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = s_if.tready;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL send_timeout word=%h not accepted", d); end
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 100 && q.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 0; m_if.tready = 1;
    @(negedge clk);
    n_cmp += 5;
    if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b want 0", m_if.tvalid); end
    if (m_if.tdata !== '0)    begin n_err++; $display("FAIL rst_tdata got %h want 0", m_if.tdata); end
    if (m_if.tuser !== '0)    begin n_err++; $display("FAIL rst_tuser got %h want 0", m_if.tuser); end
    if (m_if.tlast !== 1'b0)  begin n_err++; $display("FAIL rst_tlast got %b want 0", m_if.tlast); end
    if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL rst_s_tready got %b want 1", s_if.tready); end
`ifdef TAG_FRAME_PACK_ERR_EN
    n_cmp++;
    if (err_status !== 3'b000) begin n_err++; $display("FAIL rst_err got %b want 000", err_status); end
`endif
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic check_two_frame(input string nm);
    logic [DW-1:0] e0, e1;
    e0 = {64'h44, 64'h33, 64'h22, 64'h11};
    e1 = {64'h88, 64'h77, 64'h66, 64'h55};
    n_cmp++;
    if (q.size() !== 2) begin n_err++; $display("FAIL %s_count got %0d want 2", nm, q.size()); end
    else begin
      n_cmp += 6;
      if (q[0].d !== e0) begin n_err++; $display("FAIL %s_b0_data got %h want %h", nm, q[0].d, e0); end
      if (q[0].u !== '0) begin n_err++; $display("FAIL %s_b0_user got %h want 0", nm, q[0].u); end
      if (q[0].l !== 1'b0) begin n_err++; $display("FAIL %s_b0_last got %b want 0", nm, q[0].l); end
      if (q[1].d !== e1) begin n_err++; $display("FAIL %s_b1_data got %h want %h", nm, q[1].d, e1); end
      if (q[1].u !== 20'h00088) begin n_err++; $display("FAIL %s_b1_user got %h want 00088", nm, q[1].u); end
      if (q[1].l !== 1'b1) begin n_err++; $display("FAIL %s_b1_last got %b want 1", nm, q[1].l); end
    end
  endtask

  task automatic test_basic();
    q.delete();
    for (int i = 0; i < 4; i++) send(64'h11 * (i + 1), 5'd3, 1'b0);
    n_cmp++;
    if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL latency_tvalid got %b want 1", m_if.tvalid); end
    for (int i = 4; i < 8; i++) send(64'h11 * (i + 1), 5'd7, i == 7);
    wait_beats(2);
    check_two_frame("basic");
`ifdef TAG_FRAME_PACK_ERR_EN
    n_cmp++;
    if (err_status !== 3'b000) begin n_err++; $display("FAIL basic_err got %b want 000", err_status); end
`endif
  endtask

  task automatic test_stall();
    logic [DW-1:0] e0;
    e0 = {64'h44, 64'h33, 64'h22, 64'h11};
    q.delete();
    m_if.tready = 1'b0;
    for (int i = 0; i < 4; i++) send(64'h11 * (i + 1), 5'd3, 1'b0);
    s_if.tvalid = 1'b1; s_if.tdata = 64'h55; s_if.tuser = 5'd7; s_if.tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp += 3;
      if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL stall_s_tready cyc%0d got %b want 0", i, s_if.tready); end
      if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL stall_tvalid cyc%0d got %b want 1", i, m_if.tvalid); end
      if (m_if.tdata !== e0) begin n_err++; $display("FAIL stall_hold cyc%0d got %h want %h", i, m_if.tdata, e0); end
    end
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    for (int i = 4; i < 8; i++) send(64'h11 * (i + 1), 5'd7, i == 7);
    wait_beats(2);
    check_two_frame("stall");
  endtask

  task automatic test_premature();
    logic [DW-1:0] e;
    e = {64'h0, 64'h0, 64'hB, 64'hA};
    q.delete();
    send(64'hA, 5'd2, 1'b0);
    send(64'hB, 5'd2, 1'b1);
    wait_beats(1);
    n_cmp++;
    if (q.size() !== 1) begin n_err++; $display("FAIL short_count got %0d want 1", q.size()); end
    else begin
      n_cmp += 3;
      if (q[0].d !== e) begin n_err++; $display("FAIL short_data got %h want %h", q[0].d, e); end
      if (q[0].u !== 20'h00004) begin n_err++; $display("FAIL short_user got %h want 00004", q[0].u); end
      if (q[0].l !== 1'b1) begin n_err++; $display("FAIL short_last got %b want 1", q[0].l); end
    end
`ifdef TAG_FRAME_PACK_ERR_EN
    n_cmp++;
    if (err_status !== 3'b001) begin n_err++; $display("FAIL short_err got %b want 001", err_status); end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    n_cmp++;
    if (err_status !== 3'b000) begin n_err++; $display("FAIL err_clr got %b want 000", err_status); end
`endif
  endtask

  task automatic test_bad_tag();
    logic [DW-1:0] e;
    e = {64'h4, 64'h3, 64'h2, 64'h1};
    q.delete();
    for (int i = 0; i < 4; i++) send(64'(i + 1), 5'd25, i == 3);
    wait_beats(1);
    n_cmp++;
    if (q.size() !== 1) begin n_err++; $display("FAIL oob_count got %0d want 1", q.size()); end
    else begin
      n_cmp += 3;
      if (q[0].d !== e) begin n_err++; $display("FAIL oob_data got %h want %h", q[0].d, e); end
      if (q[0].u !== '0) begin n_err++; $display("FAIL oob_user got %h want 0", q[0].u); end
      if (q[0].l !== 1'b1) begin n_err++; $display("FAIL oob_last got %b want 1", q[0].l); end
    end
`ifdef TAG_FRAME_PACK_ERR_EN
    n_cmp++;
    if (err_status !== 3'b010) begin n_err++; $display("FAIL oob_err got %b want 010", err_status); end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
`endif
    q.delete();
    for (int i = 0; i < 8; i++) send(64'h50 + 64'(i), 5'd5, i == 7);
    wait_beats(2);
    n_cmp++;
    if (q.size() !== 2) begin n_err++; $display("FAIL dup_count got %0d want 2", q.size()); end
    else begin
      n_cmp += 2;
      if (q[0].u !== '0) begin n_err++; $display("FAIL dup_b0_user got %h want 0", q[0].u); end
      if (q[1].u !== 20'h00020) begin n_err++; $display("FAIL dup_b1_user got %h want 00020", q[1].u); end
    end
`ifdef TAG_FRAME_PACK_ERR_EN
    n_cmp++;
    if (err_status !== 3'b100) begin n_err++; $display("FAIL dup_err got %b want 100", err_status); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    e = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
    q.delete();
    send(64'h1, 5'd1, 1'b0);
    send(64'h2, 5'd1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid got %b want 0", m_if.tvalid); end
    if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL midrst_s_tready got %b want 1", s_if.tready); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(64'hC1 + 64'(i), 5'd9, i == 3);
    wait_beats(1);
    n_cmp++;
    if (q.size() !== 1) begin n_err++; $display("FAIL midrst_count got %0d want 1", q.size()); end
    else begin
      n_cmp += 3;
      if (q[0].d !== e) begin n_err++; $display("FAIL midrst_data got %h want %h", q[0].d, e); end
      if (q[0].u !== 20'h00200) begin n_err++; $display("FAIL midrst_user got %h want 00200", q[0].u); end
      if (q[0].l !== 1'b1) begin n_err++; $display("FAIL midrst_last got %b want 1", q[0].l); end
    end
`ifdef TAG_FRAME_PACK_ERR_EN
    n_cmp++;
    if (err_status !== 3'b000) begin n_err++; $display("FAIL midrst_err got %b want 000", err_status); end
`endif
  endtask

  task automatic test_back_to_back();
    int c0, el;
    logic [DW-1:0] e1;
    e1 = {64'h107, 64'h106, 64'h105, 64'h104};
    q.delete();
    c0 = cyc;
    for (int i = 0; i < 12; i++) send(64'h100 + 64'(i), 5'(i / 4), i == 11);
    el = cyc - c0;
    n_cmp++;
    if (el !== 12) begin n_err++; $display("FAIL b2b_cycles got %0d want 12", el); end
    wait_beats(3);
    n_cmp++;
    if (q.size() !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", q.size()); end
    else begin
      n_cmp += 4;
      if (q[1].d !== e1) begin n_err++; $display("FAIL b2b_b1_data got %h want %h", q[1].d, e1); end
      if (q[1].l !== 1'b0) begin n_err++; $display("FAIL b2b_b1_last got %b want 0", q[1].l); end
      if (q[2].u !== 20'h00007) begin n_err++; $display("FAIL b2b_b2_user got %h want 00007", q[2].u); end
      if (q[2].l !== 1'b1) begin n_err++; $display("FAIL b2b_b2_last got %b want 1", q[2].l); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_premature();
    test_bad_tag();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tag_frame_pack.md
TAG_FRAME_PACK -- requirements
Module: tag_frame_pack

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 20, number of tags tracked per frame.
REQ-002 SHALL have parameter NUM_CHANNELS, default 4, channel words packed per output beat.
REQ-003 SHALL have parameter CHANNEL_WIDTH, default 64, bits per channel word; output beat width DATA_WIDTH = NUM_CHANNELS*CHANNEL_WIDTH; TAG_BITS = clog2(NUM_TAGS).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all logic.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 s_axis_tvalid  input  1; s_axis_tready  output  1; s_axis_tdata  input  CHANNEL_WIDTH, one channel word; s_axis_tuser  input  TAG_BITS, tag id; s_axis_tlast  input  1, last word of frame.
REQ-008 m_axis_tvalid  output  1; m_axis_tready  input  1; m_axis_tdata  output  DATA_WIDTH, packed beat; m_axis_tuser  output  NUM_TAGS, frame tag bitmap; m_axis_tlast  output  1, last beat of frame.

Function
REQ-009 Input transfer SHALL occur when s_axis_tvalid & s_axis_tready; output transfer when m_axis_tvalid & m_axis_tready.
REQ-010 s_axis_tready SHALL equal ~m_axis_tvalid | m_axis_tready; the input stall is combinational from m_axis_tready only.
REQ-011 A channel counter 0..NUM_CHANNELS-1 SHALL select lane; accepted word SHALL be written to assembly bits [cnt*CHANNEL_WIDTH +: CHANNEL_WIDTH]; counter wraps to 0 after NUM_CHANNELS-1.
REQ-012 Tag id SHALL be captured on the cnt=0 word; tuser on later words of the same beat SHALL be ignored.
REQ-013 On acceptance of the cnt=NUM_CHANNELS-1 word, output register SHALL load the assembled beat and m_axis_tvalid SHALL assert on the next cycle (latency 1).
REQ-014 Frame bitmap SHALL set bit [captured tag] for each emitted beat; tag id >= NUM_TAGS SHALL set no bit, beat still emitted.
REQ-015 m_axis_tlast SHALL equal s_axis_tlast of the word completing the beat; m_axis_tuser SHALL be the bitmap including that beat's tag, valid with tlast (zero on non-last beats).
REQ-016 Bitmap SHALL clear on the cycle the tlast beat is loaded into the output register; the next frame starts from an empty bitmap.
REQ-017 s_axis_tlast on word cnt<NUM_CHANNELS-1 (premature end) SHALL emit the beat immediately with remaining lanes zero, tlast=1, and reset counter to 0.
REQ-018 Output register contents SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 Simultaneous output drain and load SHALL be allowed: back-to-back beats at full rate, no bubble.
REQ-020 Downstream deasserting m_axis_tready for any number of cycles (including one cycle after tlast) SHALL lose no data.

Reset
REQ-021 While rst_n=0: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, counter=0, bitmap=0, assembly=0; s_axis_tready=1.
REQ-022 Reset asserted mid-beat or mid-frame SHALL discard partial data; first word after release is cnt=0 of a new frame.

Configuration
REQ-023 Macro TAG_FRAME_PACK_ERR_EN defined: ports err_clr input 1 and err_status output 3 SHALL exist; sticky bits [0] premature tlast, [1] tag id >= NUM_TAGS, [2] duplicate tag within frame; cleared by reset or err_clr=1 (set wins over clear same cycle).
REQ-024 Macro TAG_FRAME_PACK_ERR_EN undefined: err_clr and err_status SHALL be absent; datapath behaviour identical.

Verification
REQ-025 Tags 3,7 each 4 words 0x11..0x44 / 0x55..0x88, tlast on 8th, tready=1 -> 2 beats, second tlast=1, tuser=0x00088.
REQ-026 Same stimulus, m_axis_tready low 5 cycles at beat 1 -> s_axis_tready low, beat held unchanged, both beats delivered in order.
REQ-027 Tag 2, two words 0xA, 0xB, tlast on 2nd -> one beat lanes {0,0,0xB,0xA}, tlast=1, tuser=0x00004, err_status[0]=1 with ERR_EN.
REQ-028 Tag 25 (NUM_TAGS=20) beat with tlast -> beat emitted, tuser=0, err_status[1]=1; tag 5 twice in frame -> bit5 only, err_status[2]=1.
REQ-029 rst_n pulse low after 2 words of a beat -> no output; next 4 words produce exactly one beat with counter from lane 0.
